deserializer_framed: RTL and testbench

DESERIALIZER_FRAMED -- requirements
Module: deserializer_framed

---
 rtl/fir_filter_pkg.sv | 17 +
 rtl/deserializer_framed.sv | 156 +++++++++++++++
 tb/tb_deserializer_framed.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fir_filter_pkg.sv
// -----------------------------------------------------------------------------
// fir_filter_pkg
// Shared definitions for the framed serial-to-parallel deserializer:
//   state_t        FSM state encoding (ST_IDLE, ST_SHIFT)
//   DEFAULT_WIDTH  default assembled sample width in bits
// -----------------------------------------------------------------------------
package fir_filter_pkg;

   // IDLE waits for the first frame marker; SHIFT assembles words continuously.
   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_SHIFT = 1'b1
   } state_t;

   localparam int DEFAULT_WIDTH = 24;

endpackage : fir_filter_pkg

// File: rtl/deserializer_framed.sv
// -----------------------------------------------------------------------------
// deserializer_framed
// Collects LANES serial bits per strobed beat into a WIDTH-bit word. A frame
// marker (i_sync) marks beat 0 of a word. Completed words are handed over
// through a single holding register with a valid/ready handshake.
//
// Parameters
//   WIDTH      output word width (must be a multiple of LANES)
//   LANES      serial bits delivered per beat
//   MSB_FIRST  0: first beat fills the LSB slot, 1: first beat fills the MSB slot
//
// Ports
//   i_clk       clock, all state updates on the rising edge
//   i_rst_n     asynchronous active-low reset
//   i_en        beat strobe; iv_din / i_sync only count when high
//   i_sync      frame marker, beat carrying it is beat 0 of a word
//   iv_din      lane bits of the current beat (lane 0 = lowest bit of a slot)
//   ov_dout     holding register with the last accepted word
//   o_valid     ov_dout holds a word not yet taken by the consumer
//   i_ready     consumer takes the word when o_valid && i_ready
//   o_overrun   sticky: a completed word was dropped (holding register full)
//   o_sync_err  sticky: a frame marker arrived in the middle of a word
//   i_clr_err   synchronous clear of both sticky flags (set events win)
// -----------------------------------------------------------------------------
module deserializer_framed
   import fir_filter_pkg::*;
#(
   parameter int WIDTH     = DEFAULT_WIDTH,
   parameter int LANES     = 1,
   parameter bit MSB_FIRST = 1'b0
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_en,
   input  logic             i_sync,
   input  logic [LANES-1:0] iv_din,
   output logic [WIDTH-1:0] ov_dout,
   output logic             o_valid,
   input  logic             i_ready,
   output logic             o_overrun,
   output logic             o_sync_err,
   input  logic             i_clr_err
);

   localparam int BEATS = WIDTH / LANES;
   localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

   // Bit offset of beat k inside the assembled word.
   function automatic int slot_base(input int k);
      return (MSB_FIRST ? (BEATS - 1 - k) : k) * LANES;
   endfunction

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] asm_q, asm_d;
   logic [WIDTH-1:0] dout_q, dout_d;
   logic             valid_q, valid_d;
   logic             ovr_q, ovr_d;
   logic             serr_q, serr_d;

   logic             take;
   logic [CNT_W-1:0] slot;
   logic             complete;
   logic             ovr_set;
   logic             serr_set;

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      asm_d    = asm_q;
      dout_d   = dout_q;
      valid_d  = valid_q;
      take     = 1'b0;
      slot     = '0;
      complete = 1'b0;
      ovr_set  = 1'b0;
      serr_set = 1'b0;

      // A strobed marker always restarts at beat 0; a marker without the
      // strobe is not a beat and is ignored entirely.
      if (i_en) begin
         if (i_sync) begin
            take = 1'b1;
            slot = '0;
            if ((state_q == ST_SHIFT) && (cnt_q != '0)) begin
               serr_set = 1'b1;
            end
         end else if (state_q == ST_SHIFT) begin
            take = 1'b1;
            slot = cnt_q;
         end
      end

      if (take) begin
         // Drop any partial word on a marker so no stale slots can leak.
         if (i_sync) begin
            asm_d = '0;
         end
         for (int k = 0; k < BEATS; k++) begin
            if (slot == CNT_W'(k)) begin
               asm_d[slot_base(k) +: LANES] = iv_din;
            end
         end
         if (slot == LAST_BEAT) begin
            complete = 1'b1;
            cnt_d    = '0;
         end else begin
            cnt_d = slot + 1'b1;
         end
         state_d = ST_SHIFT;
      end

      // Hand-over: a word completing while the consumer takes the old one
      // loads straight away, so back-to-back words need no bubble.
      if (complete) begin
         if (!valid_q || i_ready) begin
            dout_d  = asm_d;
            valid_d = 1'b1;
         end else begin
            ovr_set = 1'b1;
         end
      end else if (valid_q && i_ready) begin
         valid_d = 1'b0;
      end

      ovr_d  = ovr_set  | (ovr_q  & ~i_clr_err);
      serr_d = serr_set | (serr_q & ~i_clr_err);
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         asm_q   <= '0;
         dout_q  <= '0;
         valid_q <= 1'b0;
         ovr_q   <= 1'b0;
         serr_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         asm_q   <= asm_d;
         dout_q  <= dout_d;
         valid_q <= valid_d;
         ovr_q   <= ovr_d;
         serr_q  <= serr_d;
      end
   end

   assign ov_dout    = dout_q;
   assign o_valid    = valid_q;
   assign o_overrun  = ovr_q;
   assign o_sync_err = serr_q;

endmodule : deserializer_framed

// File: tb/tb_deserializer_framed.sv
// -----------------------------------------------------------------------------
// tb_deserializer_framed
// Two instances: A = 24 bits x 1 lane LSB-first, B = 24 bits x 2 lanes
// MSB-first. Directed table and sequences first, then randomized traffic
// compared cycle by cycle against a beat-list reference model.
// -----------------------------------------------------------------------------
module tb_deserializer_framed;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n;
   logic        en_a, sync_a, rdy_a, clr_a;
   logic [0:0]  din_a;
   logic [23:0] dout_a;
   logic        vld_a, ovr_a, serr_a;
   logic        en_b, sync_b, rdy_b, clr_b;
   logic [1:0]  din_b;
   logic [23:0] dout_b;
   logic        vld_b, ovr_b, serr_b;

   deserializer_framed #(.WIDTH(24), .LANES(1), .MSB_FIRST(1'b0)) dut_a (
      .i_clk(clk), .i_rst_n(rst_n), .i_en(en_a), .i_sync(sync_a),
      .iv_din(din_a), .ov_dout(dout_a), .o_valid(vld_a), .i_ready(rdy_a),
      .o_overrun(ovr_a), .o_sync_err(serr_a), .i_clr_err(clr_a));

   deserializer_framed #(.WIDTH(24), .LANES(2), .MSB_FIRST(1'b1)) dut_b (
      .i_clk(clk), .i_rst_n(rst_n), .i_en(en_b), .i_sync(sync_b),
      .iv_din(din_b), .ov_dout(dout_b), .o_valid(vld_b), .i_ready(rdy_b),
      .o_overrun(ovr_b), .o_sync_err(serr_b), .i_clr_err(clr_b));

   int npass = 0;
   int ntot  = 0;
   bit mdl_cmp = 1'b0;

   // Reference model: list of received beats per instance.
   logic [1:0]  mbeat [2][24];
   int          mcnt  [2];
   bit          msyn  [2];
   logic [23:0] mdout [2];
   bit          mvld  [2];
   bit          movr  [2];
   bit          mserr [2];

   typedef struct {
      int          inst;
      logic [23:0] stream;   // beat k lanes at stream[k*L +: L]
      int          gaps;
      logic [23:0] exp;
   } vec_t;

   vec_t vecs [5];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      ntot++;
      if (act === exp) npass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
   endtask

   function automatic logic [23:0] get_dout(input int i);
      return (i == 0) ? dout_a : dout_b;
   endfunction
   function automatic logic get_vld(input int i);
      return (i == 0) ? vld_a : vld_b;
   endfunction
   function automatic logic get_ovr(input int i);
      return (i == 0) ? ovr_a : ovr_b;
   endfunction
   function automatic logic get_serr(input int i);
      return (i == 0) ? serr_a : serr_b;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         mcnt[i] = 0; msyn[i] = 1'b0; mdout[i] = '0;
         mvld[i] = 1'b0; movr[i] = 1'b0; mserr[i] = 1'b0;
      end
   endtask

   task automatic model_step(input int i, input logic en, input logic sync,
                             input logic [1:0] din, input logic rdy, input logic clr);
      int          L;
      int          nb;
      int          pos;
      bit          comp;
      bit          oset;
      bit          sset;
      logic [23:0] w;
      L = i + 1; nb = 24 / L; comp = 1'b0; oset = 1'b0; sset = 1'b0; w = '0;
      if (en) begin
         if (sync) begin
            if (msyn[i] && mcnt[i] != 0) sset = 1'b1;
            mcnt[i] = 0;
            msyn[i] = 1'b1;
         end
         if (msyn[i]) begin
            mbeat[i][mcnt[i]] = (L == 1) ? (din & 2'b01) : din;
            mcnt[i]++;
            if (mcnt[i] == nb) begin
               comp = 1'b1;
               mcnt[i] = 0;
               for (int k = 0; k < nb; k++) begin
                  pos = (i == 1) ? (nb - 1 - k) : k;
                  w = w | (24'(mbeat[i][k]) << (pos * L));
               end
            end
         end
      end
      if (comp) begin
         if (!mvld[i] || rdy) begin mdout[i] = w; mvld[i] = 1'b1; end
         else oset = 1'b1;
      end else if (mvld[i] && rdy) begin
         mvld[i] = 1'b0;
      end
      movr[i]  = oset | (movr[i]  & !clr);
      mserr[i] = sset | (mserr[i] & !clr);
   endtask

   task automatic tick();
      @(posedge clk);
      if (!rst_n) model_reset();
      else begin
         model_step(0, en_a, sync_a, {1'b0, din_a}, rdy_a, clr_a);
         model_step(1, en_b, sync_b, din_b, rdy_b, clr_b);
      end
      #1;
      if (mdl_cmp) begin
         for (int i = 0; i < 2; i++) begin
            chk($sformatf("rand_dout[%0d]", i), get_dout(i), mdout[i]);
            chk($sformatf("rand_valid[%0d]", i), get_vld(i), mvld[i]);
            chk($sformatf("rand_overrun[%0d]", i), get_ovr(i), movr[i]);
            chk($sformatf("rand_sync_err[%0d]", i), get_serr(i), mserr[i]);
         end
      end
   endtask

   task automatic set_beat(input int inst, input logic en, input logic sync, input logic [1:0] din);
      if (inst == 0) begin en_a = en; sync_a = sync; din_a = din[0]; end
      else begin en_b = en; sync_b = sync; din_b = din; end
   endtask

   // Gap cycles hold i_sync high without i_en to show it is ignored.
   task automatic send(input int inst, input logic [23:0] stream, input int nb,
                       input bit first_sync, input int gaps);
      int         L;
      logic [1:0] d;
      L = inst + 1;
      for (int k = 0; k < nb; k++) begin
         for (int g = 0; g < gaps; g++) begin
            set_beat(inst, 1'b0, 1'b1, 2'b11);
            tick();
         end
         d = 2'(stream >> (k * L));
         set_beat(inst, 1'b1, (k == 0) && first_sync, d);
         tick();
      end
      set_beat(inst, 1'b0, 1'b0, 2'b00);
   endtask

   initial begin
      vecs[0] = '{inst: 0, stream: 24'hA5C3F0, gaps: 0, exp: 24'hA5C3F0};
      vecs[1] = '{inst: 1, stream: 24'h951C84, gaps: 0, exp: 24'h123456};
      vecs[2] = '{inst: 1, stream: 24'h951C84, gaps: 2, exp: 24'h123456};
      vecs[3] = '{inst: 1, stream: 24'h400000, gaps: 1, exp: 24'h000001};
      vecs[4] = '{inst: 0, stream: 24'h00BEEF, gaps: 1, exp: 24'h00BEEF};

      rst_n = 1'b0;
      en_a = 0; sync_a = 0; din_a = 0; rdy_a = 1; clr_a = 0;
      en_b = 0; sync_b = 0; din_b = 0; rdy_b = 1; clr_b = 0;
      model_reset();
      repeat (3) tick();
      for (int i = 0; i < 2; i++) begin
         chk($sformatf("reset_dout[%0d]", i), get_dout(i), 24'h0);
         chk($sformatf("reset_valid[%0d]", i), get_vld(i), 1'b0);
         chk($sformatf("reset_overrun[%0d]", i), get_ovr(i), 1'b0);
         chk($sformatf("reset_sync_err[%0d]", i), get_serr(i), 1'b0);
      end
      rst_n = 1'b1;
      tick();

      // Beats before the first marker are ignored.
      send(0, 24'hFFFFFF, 5, 1'b0, 0);
      tick();
      chk("idle_no_sync_valid", vld_a, 1'b0);

      // Table: single words, valid pulses for exactly one cycle.
      for (int v = 0; v < 5; v++) begin
         send(vecs[v].inst, vecs[v].stream, 24 / (vecs[v].inst + 1), 1'b1, vecs[v].gaps);
         chk($sformatf("vec%0d_dout", v), get_dout(vecs[v].inst), vecs[v].exp);
         chk($sformatf("vec%0d_valid", v), get_vld(vecs[v].inst), 1'b1);
         chk($sformatf("vec%0d_sync_err", v), get_serr(vecs[v].inst), 1'b0);
         tick();
         chk($sformatf("vec%0d_valid_drop", v), get_vld(vecs[v].inst), 1'b0);
         chk($sformatf("vec%0d_dout_hold", v), get_dout(vecs[v].inst), vecs[v].exp);
      end

      // Overrun: second word dropped while the first is unconsumed.
      rdy_a = 1'b0;
      send(0, 24'h000001, 24, 1'b1, 0);
      chk("ovr_first_valid", vld_a, 1'b1);
      chk("ovr_first_dout", dout_a, 24'h000001);
      send(0, 24'h000002, 24, 1'b0, 0);
      chk("ovr_dout_kept", dout_a, 24'h000001);
      chk("ovr_flag", ovr_a, 1'b1);
      clr_a = 1'b1; tick(); clr_a = 1'b0;
      chk("ovr_cleared", ovr_a, 1'b0);
      rdy_a = 1'b1; tick();
      chk("ovr_consumed_valid", vld_a, 1'b0);
      chk("ovr_consumed_dout", dout_a, 24'h000001);

      // Completion coincident with consumption: no bubble, no overrun.
      rdy_a = 1'b0;
      send(0, 24'h000111, 24, 1'b1, 0);
      chk("b2b_first_valid", vld_a, 1'b1);
      send(0, 24'h000222, 23, 1'b1, 0);
      rdy_a = 1'b1;
      set_beat(0, 1'b1, 1'b0, 2'b00);
      tick();
      set_beat(0, 1'b0, 1'b0, 2'b00);
      chk("b2b_valid", vld_a, 1'b1);
      chk("b2b_dout", dout_a, 24'h000222);
      chk("b2b_overrun", ovr_a, 1'b0);
      tick();
      chk("b2b_valid_drop", vld_a, 1'b0);

      // Marker in the middle of a word.
      send(0, 24'h0000FF, 7, 1'b1, 0);
      send(0, 24'hFFFFFF, 24, 1'b1, 0);
      chk("serr_flag", serr_a, 1'b1);
      chk("serr_dout", dout_a, 24'hFFFFFF);
      send(0, 24'h0003FF, 10, 1'b1, 0);
      send(0, 24'h0F0F00, 24, 1'b1, 0);
      chk("serr_no_stale", dout_a, 24'h0F0F00);
      clr_a = 1'b1; tick(); clr_a = 1'b0;
      chk("serr_cleared", serr_a, 1'b0);
      send(0, 24'h000000, 3, 1'b1, 0);
      clr_a = 1'b1;
      set_beat(0, 1'b1, 1'b1, 2'b00);
      tick();
      clr_a = 1'b0;
      set_beat(0, 1'b0, 1'b0, 2'b00);
      chk("serr_set_wins", serr_a, 1'b1);
      clr_a = 1'b1; tick(); clr_a = 1'b0;
      chk("serr_cleared2", serr_a, 1'b0);

      // Reset mid-word, then no marker: nothing must come out.
      send(0, 24'h0003FF, 10, 1'b1, 0);
      rst_n = 1'b0;
      tick(); tick();
      rst_n = 1'b1;
      chk("rst_mid_valid", vld_a, 1'b0);
      chk("rst_mid_dout", dout_a, 24'h0);
      send(0, 24'hFFFFFF, 30, 1'b0, 0);
      tick();
      chk("rst_nosync_valid", vld_a, 1'b0);
      chk("rst_nosync_dout", dout_a, 24'h0);
      send(0, 24'h00BEEF, 24, 1'b1, 0);
      chk("rst_word_dout", dout_a, 24'h00BEEF);
      chk("rst_word_valid", vld_a, 1'b1);

      // Randomized traffic against the model.
      mdl_cmp = 1'b1;
      for (int c = 0; c < 3000; c++) begin
         en_a   = ($urandom_range(3) != 0);
         sync_a = ($urandom_range(79) == 0);
         din_a  = 1'($urandom_range(1));
         rdy_a  = ($urandom_range(2) != 0);
         clr_a  = ($urandom_range(29) == 0);
         en_b   = ($urandom_range(3) != 0);
         sync_b = ($urandom_range(39) == 0);
         din_b  = 2'($urandom_range(3));
         rdy_b  = ($urandom_range(2) != 0);
         clr_b  = ($urandom_range(29) == 0);
         tick();
      end
      mdl_cmp = 1'b0;

      $display("%0d/%0d checks passed", npass, ntot);
      $finish;
   end

endmodule : tb_deserializer_framed
